// File: rtl/uni_shift_pkg.sv
// Shared encodings for the universal shift-register links (tx and rx sides).
package uni_shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register. A load is taken when the slot is
// empty or draining this cycle; otherwise the incoming word is dropped and
// overrun pulses for one cycle.
module deser_out_reg #(
  parameter int WIDTH = uni_shift_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovr_q;
  logic             accept;

  // Slot can take a new word if empty or being consumed in this same cycle.
  assign accept = ~valid_q | ready_i;

  // Holding register, valid flag and overrun pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= load_i & ~accept;
      if (load_i && accept) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/uni_deser_rx.sv
// Serial-to-parallel receiver: one bit per strobe, direction latched at frame
// start, WIDTH bits per word, completed words handed to a holding register.
module uni_deser_rx
  import uni_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             lsb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             ferr_q, ferr_d;
  logic             done;
  logic             sh_dir;
  logic [WIDTH-1:0] shifted;

  // Direction for the current bit: a qualified frame_start overrides the latch.
  assign sh_dir  = (bit_valid && frame_start) ? lsb_first : dir_q;
  assign shifted = (sh_dir == DIR_LSB_FIRST) ? {serial_in, shreg_q[WIDTH-1:1]}
                                             : {shreg_q[WIDTH-2:0], serial_in};

  // State, counter, shift register, direction latch and frame_err pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dir_q   <= DIR_MSB_FIRST;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: start, shift, complete or abort-and-restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_valid && frame_start) begin
          dir_d   = lsb_first;
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shreg_d = shifted;
          if (frame_start) begin
            // Partial word thrown away; this bit opens the new frame.
            ferr_d = 1'b1;
            dir_d  = lsb_first;
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  deser_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load_i    (done),
    .data_i    (shreg_d),
    .ready_i   (out_ready),
    .data_o    (parallel_out),
    .valid_o   (out_valid),
    .overrun_o (overrun)
  );

  assign busy      = (state_q == SHIFT);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uni_deser_rx.sv
// Directed bench for uni_deser_rx at WIDTH=4.
module tb_uni_deser_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in, bit_valid, frame_start, lsb_first, out_ready;
  logic [W-1:0] parallel_out;
  logic         out_valid, busy, overrun, frame_err;

  int n_chk = 0;
  int n_err = 0;
  int xfers = 0;
  int x0;

  uni_deser_rx #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .lsb_first    (lsb_first),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Count handshake transfers seen at the active edge.
  always @(posedge clk) if (reset && out_valid && out_ready) xfers <= xfers + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs at a falling edge, return at the next falling edge.
  task automatic tick(input logic bv, input logic fs, input logic sin);
    bit_valid   = bv;
    frame_start = fs;
    serial_in   = sin;
    @(negedge clk);
  endtask

  // Send a 4-bit word on consecutive strobes, bits listed in send order.
  task automatic frame(input logic [3:0] bits);
    tick(1, 1, bits[3]);
    tick(1, 0, bits[2]);
    tick(1, 0, bits[1]);
    tick(1, 0, bits[0]);
  endtask

  initial begin
    reset = 1'b0; serial_in = 0; bit_valid = 0; frame_start = 0;
    lsb_first = 0; out_ready = 1;
    @(negedge clk);
    tick(0, 0, 0);
    chk("rst_pout", parallel_out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b1;
    tick(0, 0, 0);

    // 1. MSB-first 1,0,1,1
    tick(1, 1, 1); chk("t1_busy1", busy, 1);
    tick(1, 0, 0); chk("t1_busy2", busy, 1);
    tick(1, 0, 1); chk("t1_busy3", busy, 1); chk("t1_vld_early", out_valid, 0);
    tick(1, 0, 1);
    chk("t1_vld", out_valid, 1);
    chk("t1_pout", parallel_out, 4'b1011);
    chk("t1_busy_end", busy, 0);
    tick(0, 0, 0);
    chk("t1_drain", out_valid, 0);
    chk("t1_hold", parallel_out, 4'b1011);

    // 2. LSB-first, same bits
    lsb_first = 1;
    frame(4'b1011);
    lsb_first = 0;
    chk("t2_vld", out_valid, 1);
    chk("t2_pout", parallel_out, 4'b1101);
    tick(0, 0, 0);

    // 3. Gapped strobes, then stray bit in IDLE
    tick(1, 1, 1); tick(0, 0, 0); tick(0, 1, 0);
    chk("t3_busy_gap", busy, 1);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(1, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
    chk("t3_vld_gap", out_valid, 0);
    tick(1, 0, 1);
    chk("t3_vld", out_valid, 1);
    chk("t3_pout", parallel_out, 4'b1011);
    tick(0, 0, 0);
    tick(1, 0, 1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_vld", out_valid, 0);

    // 4. Backpressure and overrun
    out_ready = 0;
    frame(4'hA);
    chk("t4_vldA", out_valid, 1);
    chk("t4_poutA", parallel_out, 4'hA);
    chk("t4_no_ovr", overrun, 0);
    frame(4'h5);
    chk("t4_ovr", overrun, 1);
    chk("t4_keepA", parallel_out, 4'hA);
    tick(0, 0, 0);
    chk("t4_ovr_pulse", overrun, 0);
    chk("t4_vld_hold", out_valid, 1);
    out_ready = 1;
    tick(0, 0, 0);
    out_ready = 0;
    chk("t4_drain", out_valid, 0);
    chk("t4_pout_kept", parallel_out, 4'hA);
    out_ready = 1;

    // 5. Abort after 2 bits, new frame 0,1,1,0
    x0 = xfers;
    tick(1, 1, 1); tick(1, 0, 1);
    tick(1, 1, 0);
    chk("t5_ferr", frame_err, 1);
    chk("t5_busy", busy, 1);
    tick(1, 0, 1);
    chk("t5_ferr_pulse", frame_err, 0);
    tick(1, 0, 1);
    chk("t5_vld_early", out_valid, 0);
    tick(1, 0, 0);
    chk("t5_vld", out_valid, 1);
    chk("t5_pout", parallel_out, 4'b0110);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("t5_one_word", xfers - x0, 1);

    // 5b. Abort at the last-bit position (count = WIDTH-1)
    tick(1, 1, 0); tick(1, 0, 0); tick(1, 0, 0);
    frame(4'b1001);
    chk("t5b_ferr_pulse", frame_err, 0);
    chk("t5b_pout", parallel_out, 4'b1001);
    tick(0, 0, 0);

    // 6. Reset mid-frame
    tick(1, 1, 1); tick(1, 0, 1); tick(1, 0, 1);
    reset = 0;
    tick(0, 0, 0);
    reset = 1;
    chk("t6_busy", busy, 0);
    chk("t6_vld", out_valid, 0);
    chk("t6_pout", parallel_out, 0);
    chk("t6_flags", {overrun, frame_err}, 0);
    tick(1, 0, 1);
    tick(0, 0, 0);
    chk("t6_ignored_busy", busy, 0);
    chk("t6_ignored_vld", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uni_deser_rx.md
Name: uni_deser_rx

Overview:
Serial-to-parallel receiver; the receive end of the serial links driven by our universal shift registers in shift-left or shift-right mode. Accepts one qualified bit per strobe, MSB-first or LSB-first as selected at frame start, and assembles WIDTH bits into a word. Presents each completed word on a valid/ready output port with a one-word holding register, plus overrun and framing-error flags.

Parameters:
WIDTH, 4, word length in bits (>= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
serial_in  input  1  serial data bit
bit_valid  input  1  serial_in is a valid bit this cycle
frame_start  input  1  qualified by bit_valid; the current bit is bit 0 of a new word
lsb_first  input  1  direction; sampled only on a qualified frame_start (1 = LSB-first, 0 = MSB-first)
out_ready  input  1  downstream accepts parallel_out this cycle
parallel_out  output  WIDTH  received word; stable while out_valid=1
out_valid  output  1  parallel_out holds an unconsumed word
busy  output  1  frame in progress (state SHIFT)
overrun  output  1  one-cycle pulse: completed word dropped because holding register full
frame_err  output  1  one-cycle pulse: partial word aborted by a new frame_start

Behaviour:
- reset=0 at a rising edge: state IDLE, bit counter 0, shift register 0, parallel_out 0, out_valid 0, busy 0, overrun 0, frame_err 0. Applies mid-frame; the partial word is discarded with no flag.
- FSM states: IDLE, SHIFT.
  - IDLE: bit_valid without frame_start is ignored. bit_valid&frame_start latches lsb_first, shifts in the bit, sets count=1, and moves to SHIFT.
  - SHIFT: each bit_valid shifts one bit and increments count.
    - Cycles without bit_valid hold all state; there is no timeout.
    - On the WIDTH-th bit the word completes, count returns to 0, and state returns to IDLE. The next word needs a new frame_start.
- Shift rules (shreg is WIDTH bits):
  - MSB-first: shreg <= {shreg[WIDTH-2:0], serial_in}.
  - LSB-first: shreg <= {serial_in, shreg[WIDTH-1:1]}.
  - The completed word includes the bit accepted in the completing cycle.
- frame_start with bit_valid while in SHIFT (any count, including count=WIDTH-1):
  - The partial word is discarded and frame_err pulses for 1 cycle.
  - The current bit becomes bit 0 of the new frame, count=1, and direction is re-latched.
  - No word is delivered.
- frame_start without bit_valid: ignored in every state.
- Output handshake:
  - Transfer occurs when out_valid & out_ready at a rising edge.
  - A completed word is written to parallel_out, with out_valid=1, in the cycle after the last bit is accepted (latency 1 from last bit).
  - If out_valid=0, or out_valid&out_ready in the completion cycle, the new word loads. Simultaneous drain and load keeps out_valid at 1 with the new data.
  - If out_valid=1 and out_ready=0 in the completion cycle, the new word is dropped, the held word is kept, and overrun pulses for 1 cycle.
  - out_valid falls the cycle after a transfer with no new load. parallel_out keeps its last value when out_valid=0.
- busy = (state == SHIFT), registered.
- Bit counter width is $clog2(WIDTH). Counter wrap occurs only via completion or abort.

Decomposition:
- Shared package uni_shift_pkg: state enum (IDLE, SHIFT), direction constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1, and default WIDTH=4, so the transmit side and the receiver agree on encodings.
- One natural sub-module: deser_out_reg, the single-entry valid/ready holding register with overrun detection.
- Shift register, counter and FSM stay in the top level.

Test Plan (WIDTH=4):
1. MSB-first: frame_start with bits 1,0,1,1 on consecutive cycles, out_ready=1 -> parallel_out=4'b1011 and out_valid=1 one cycle after the 4th bit; busy high for the 3 cycles after the first bit.
2. LSB-first: lsb_first=1 with the same bit sequence 1,0,1,1 -> parallel_out=4'b1101.
3. Gapped strobes: same MSB-first frame with 2 idle cycles between bits -> parallel_out=4'b1011. bit_valid=1 without frame_start in IDLE -> no state change, busy stays 0.
4. Backpressure: out_ready=0; receive 4'hA, then 4'h5 -> parallel_out stays 4'hA, overrun pulses once. Then out_ready=1 for 1 cycle -> out_valid falls next cycle.
5. Abort: 2 bits, then frame_start with bits 0,1,1,0 (MSB-first) -> frame_err pulses once; parallel_out=4'b0110; exactly one word delivered.
6. Reset mid-frame: reset=0 for 1 cycle after 3 bits -> next cycle all outputs 0 and busy=0. A 4th bit without frame_start is ignored and out_valid stays 0.
